// File: rtl/scanline_fetch_arbiter.sv
// Line-buffered scanline fetcher: prefetches each visible line into a small pixel FIFO
// ahead of the beam and shares the memory port with host writes, display reads first.
module scanline_fetch_arbiter #(
  parameter int H_RESOLUTION = 640,
  parameter int V_RESOLUTION = 480,
  parameter int FETCH_LEAD   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8
) (
  input  logic               i_pixel_clk,
  input  logic               i_reset,
  input  logic signed [12:0] i_x,
  input  logic signed [12:0] i_y,
  input  logic               i_frame_start,
  input  logic               i_wr_valid,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0]  i_wr_data,
  output logic               o_wr_ready,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_rd,
  output logic               o_mem_we,
  output logic [DATA_W-1:0]  o_mem_wdata,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  output logic [DATA_W-1:0]  o_pixel,
  output logic               o_underflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(H_RESOLUTION);
  localparam logic signed [12:0] H_S    = 13'(H_RESOLUTION);
  localparam logic signed [12:0] H_LAST = 13'(H_RESOLUTION - 1);
  localparam logic signed [12:0] V_S    = 13'(V_RESOLUTION);
  localparam logic signed [12:0] LEAD_S = 13'(-FETCH_LEAD);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW:0]        occ_q, occ_d;
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_d [FIFO_DEPTH];
  logic               inflight_q, inflight_d;
  logic [DATA_W-1:0]  pixel_q, pixel_d;
  logic               underflow_q, underflow_d;

  logic               x_vis, y_vis, pop_win, line_end, push, wr_ok, rd_issue;
  logic [PW+1:0]      fill;

  assign x_vis    = !i_x[12] && (i_x < H_S);
  assign y_vis    = !i_y[12] && (i_y < V_S);
  assign pop_win  = x_vis && y_vis;
  assign line_end = pop_win && (i_x == H_LAST);
  assign fill     = {1'b0, occ_q} + {{(PW+1){1'b0}}, inflight_q};

  // Reads already in flight count against capacity so a push can never hit a full FIFO.
  assign rd_issue = !i_reset && !i_frame_start && (state_q == FETCH) &&
                    (fill < (PW+2)'(FIFO_DEPTH));
  assign o_wr_ready  = !i_reset && !rd_issue;
  assign wr_ok       = i_wr_valid && o_wr_ready;
  assign o_mem_rd    = rd_issue;
  assign o_mem_we    = wr_ok;
  assign o_mem_addr  = rd_issue ? addr_q : (wr_ok ? i_wr_addr : '0);
  assign o_mem_wdata = wr_ok ? i_wr_data : '0;
  assign o_pixel     = pixel_q;
  assign o_underflow = underflow_q;

  // A return landing on the last pixel of a line belongs to a stale fetch.
  assign push = inflight_q && !line_end;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    occ_d       = occ_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    fifo_d      = fifo_q;
    inflight_d  = rd_issue;
    pixel_d     = '0;
    underflow_d = underflow_q;
    if (i_frame_start) begin
      state_d     = IDLE;
      occ_d       = '0;
      wptr_d      = '0;
      rptr_d      = '0;
      inflight_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wptr_q] = i_mem_rdata;
        wptr_d         = wptr_q + PW'(1);
      end
      if (pop_win) begin
        if (occ_q != '0) begin
          pixel_d = fifo_q[rptr_q];
          rptr_d  = rptr_q + PW'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
      occ_d = occ_q + (PW+1)'(push) - (PW+1)'(pop_win && (occ_q != '0));
      case (state_q)
        IDLE: if (i_x == LEAD_S && y_vis) begin
          state_d = FETCH;
          addr_d  = ADDR_W'({{ADDR_W{1'b0}}, i_y} * H_RESOLUTION);
          cnt_d   = '0;
        end
        FETCH: if (rd_issue) begin
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_q == CW'(H_RESOLUTION - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      occ_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      inflight_q  <= 1'b0;
      pixel_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      occ_q       <= occ_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      inflight_q  <= inflight_d;
      pixel_q     <= pixel_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge i_pixel_clk) fifo_q <= fifo_d;

endmodule

// File: tb/tb_scanline_fetch_arbiter.sv
// Directed beam sequence with random host traffic, checked against a queue-based line model.
module tb_scanline_fetch_arbiter;
  localparam int H = 640, V = 480, LEAD = 8, DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst, fs, wr_valid;
  logic signed [12:0] i_x, i_y;
  logic [18:0]       wr_addr, mem_addr;
  logic [7:0]        wr_data, mem_wdata, mem_rdata, pixel;
  logic              wr_ready, mem_rd, mem_we, underflow;

  int n_tests = 0, n_fail = 0;
  int wr_mode = 0;
  bit stall = 0, fcheck = 0;

  // reference model state
  bit         m_fetch = 0, m_inf = 0, m_uf = 0;
  int         m_addr = 0, m_cnt = 0;
  logic [7:0] m_inf_d = 0, m_pix = 0;
  logic [7:0] q[$];

  scanline_fetch_arbiter dut (
    .i_pixel_clk(clk), .i_reset(rst), .i_x(i_x), .i_y(i_y), .i_frame_start(fs),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_pixel(pixel), .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  // memory word k holds k[7:0]
  always @(posedge clk) mem_rdata <= mem_rd ? mem_addr[7:0] : 8'h5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int x, input int y, input bit f, input bit r);
    bit vis, le, e_rd, e_rdy, e_we;
    logic [18:0] e_addr;
    logic [7:0]  e_wd;
    @(negedge clk);
    i_x = 13'(x); i_y = 13'(y); fs = f; rst = r;
    wr_valid = (wr_mode == 1) || (wr_mode == 2 && $urandom_range(0, 1) == 1);
    wr_addr  = 19'($urandom);
    wr_data  = 8'($urandom);
    #2;
    vis    = (x >= 0 && x < H && y >= 0 && y < V);
    le     = vis && (x == H - 1);
    e_rd   = !r && !f && !stall && m_fetch && (q.size() + int'(m_inf) < DEPTH);
    e_rdy  = !r && !e_rd;
    e_we   = wr_valid && e_rdy;
    e_addr = e_rd ? 19'(m_addr) : (e_we ? wr_addr : 19'd0);
    e_wd   = e_we ? wr_data : 8'd0;
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    chk("wr_ready", 32'(wr_ready), 32'(e_rdy));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    if (!r && (y < 0 || y >= V)) begin
      chk("blank_rd", 32'(mem_rd), 32'd0);
      chk("blank_rdy", 32'(wr_ready), 32'd1);
    end
    if (y == 11 && x == -LEAD + 1) begin
      chk("l11_first_rd", 32'(mem_rd), 32'd1);
      chk("l11_first_addr", 32'(mem_addr), 32'd7040);
    end
    if (y == 10 && x > 302) chk("l10_no_fetch", 32'(mem_rd), 32'd0);
    @(posedge clk);
    if (r || f) begin
      m_fetch = 0; m_inf = 0; m_uf = 0; m_pix = 0;
      q.delete();
    end else begin
      if (vis) begin
        if (q.size() > 0) m_pix = q.pop_front();
        else begin m_pix = 0; m_uf = 1; end
      end else m_pix = 0;
      if (m_inf && !le) q.push_back(m_inf_d);
      m_inf   = e_rd;
      m_inf_d = 8'(m_addr);
      if (m_fetch) begin
        if (e_rd) begin
          m_addr++; m_cnt++;
          if (m_cnt == H) m_fetch = 0;
        end
      end else if (x == -LEAD && y >= 0 && y < V) begin
        m_fetch = 1; m_addr = y * H; m_cnt = 0;
      end
    end
    #1;
    chk("pixel", 32'(pixel), 32'(m_pix));
    chk("underflow", 32'(underflow), 32'(m_uf));
    if (fcheck && vis) chk("line_pix", 32'(pixel), 32'((y * H + x) & 255));
  endtask

  task automatic run_line(input int y, input int mode, input bit fc, input bit stl);
    wr_mode = mode;
    fcheck  = fc;
    for (int x = -160; x < H; x++) begin
      if (stl && x == 200) begin stall = 1; force dut.rd_issue = 1'b0; end
      if (stl && x == 220) begin stall = 0; release dut.rd_issue; end
      cyc(x, y, 1'b0, (y == 10 && x >= 300 && x < 303));
    end
    fcheck = 0;
  endtask

  initial begin
    rst = 1; fs = 0; i_x = 0; i_y = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
    repeat (3) cyc(-160, -1, 1'b0, 1'b1);
    cyc(-159, -1, 1'b1, 1'b0);
    run_line(-1, 2, 0, 0);
    run_line(4, 0, 1, 0);
    run_line(5, 0, 1, 0);
    run_line(6, 1, 1, 0);
    run_line(10, 2, 0, 0);
    run_line(11, 0, 1, 0);
    cyc(-160, -1, 1'b1, 1'b0);
    chk("uf_cleared_fs", 32'(underflow), 32'd0);
    run_line(7, 2, 0, 1);
    chk("uf_after_stall", 32'(underflow), 32'd1);
    run_line(8, 0, 0, 0);
    chk("uf_sticky", 32'(underflow), 32'd1);
    cyc(-160, -1, 1'b1, 1'b0);
    chk("uf_cleared", 32'(underflow), 32'd0);
    run_line(480, 2, 0, 0);
    run_line(481, 2, 0, 0);
    run_line(12, 2, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scanline_fetch_arbiter.md
SCANLINE_FETCH_ARBITER -- requirements
Module: scanline_fetch_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- H_RESOLUTION, 640, visible pixels per line
- V_RESOLUTION, 480, visible lines
- FETCH_LEAD, 8, pixel clocks before x=0 at which the line fetch starts
- FIFO_DEPTH, 8, pixel FIFO entries (power of two, FIFO_DEPTH <= FETCH_LEAD)
- ADDR_W, 19, memory address width
- DATA_W, 8, pixel/memory word width
REQ-002 Ports (name, direction, width, meaning):
- i_pixel_clk, in, 1, pixel clock
- i_reset, in, 1, reset (synchronous, active-high)
- i_x, in, 13 signed, beam x from timing generator (negative in blanking)
- i_y, in, 13 signed, beam y from timing generator (negative in blanking)
- i_frame_start, in, 1, one-cycle frame start pulse
- i_wr_valid, in, 1, host write request
- i_wr_addr, in, ADDR_W, host write address
- i_wr_data, in, DATA_W, host write data
- o_wr_ready, out, 1, host write accepted this cycle when high together with i_wr_valid
- o_mem_addr, out, ADDR_W, memory address
- o_mem_rd, out, 1, memory read strobe
- o_mem_we, out, 1, memory write strobe
- o_mem_wdata, out, DATA_W, memory write data
- i_mem_rdata, in, DATA_W, read data, valid exactly one cycle after o_mem_rd
- o_pixel, out, DATA_W, registered pixel for display
- o_underflow, out, 1, sticky FIFO-underflow flag

Function
REQ-003 FSM states: IDLE, FETCH. IDLE->FETCH when i_x == -FETCH_LEAD and 0 <= i_y < V_RESOLUTION; FETCH->IDLE when H_RESOLUTION reads have been issued.
REQ-004 On entry to FETCH: fetch address = i_y*H_RESOLUTION (ADDR_W bits, unsigned, truncated); issued-read counter = 0.
REQ-005 In FETCH, a display read is issued (o_mem_rd=1, o_mem_addr=fetch address, post-increment address and counter) when occupancy + in-flight reads < FIFO_DEPTH.
REQ-006 At most one memory operation per cycle; o_mem_rd and o_mem_we never both high.
REQ-007 o_wr_ready (combinational) = 1 when no display read is issued this cycle, including all cycles in IDLE; the display fetch has strict priority.
REQ-008 When i_wr_valid && o_wr_ready: o_mem_we=1, o_mem_addr=i_wr_addr, o_mem_wdata=i_wr_data in the same cycle.
REQ-009 The cycle after a display read, i_mem_rdata is pushed into the FIFO.
REQ-010 Pop condition: 0 <= i_x < H_RESOLUTION and 0 <= i_y < V_RESOLUTION; one pop per cycle.
REQ-011 Pop with FIFO non-empty: o_pixel <= head entry on the next edge, so o_pixel shows pixel n one cycle after i_x == n.
REQ-012 Pop with FIFO empty: o_pixel <= 0; o_underflow <= 1.
REQ-013 o_underflow is sticky until the next i_frame_start.
REQ-014 Push and pop in the same cycle leave occupancy unchanged; push to a full FIFO cannot occur (guaranteed by REQ-005).
REQ-015 Outside the pop window, o_pixel <= 0.
REQ-016 On i_frame_start: FIFO flushed, in-flight read data discarded, state IDLE, o_underflow cleared. The frame-start clear wins over a same-cycle underflow set.
REQ-017 A read-data return in the same cycle as a line end or frame start is discarded, never pushed.

Reset
REQ-018 While i_reset is high: state IDLE; FIFO empty; in-flight cleared; o_pixel=0; o_underflow=0; o_mem_rd=0; o_mem_we=0; o_mem_addr=0; o_mem_wdata=0; o_wr_ready=0.
REQ-019 Reset asserted mid-line aborts the fetch; after release the block waits for the next i_x == -FETCH_LEAD on a visible line.

Verification
REQ-020 Drive a 640x480 beam with memory word k = k[7:0] and no host traffic -> line y=5 gives o_pixel = (3200+n)[7:0] at the cycle after i_x = n for n = 0..639; o_underflow stays 0.
REQ-021 Hold i_wr_valid=1 continuously -> o_wr_ready=0 exactly on display-read cycles; every accepted write appears on o_mem_we with matching address and data; the displayed line is still correct.
REQ-022 Memory stall model that drops o_mem_rd returns for 20 cycles mid-line (force FIFO empty) -> o_pixel=0 at the starved pixels; o_underflow=1 until i_frame_start, then 0.
REQ-023 Assert i_reset for 3 cycles at line y=10, x=300 -> all outputs take their reset values; line 10 is not fetched; line 11 fetch starts at i_x = -8 with address 7040.
REQ-024 Lines y<0 and y=480..(end of frame) -> o_mem_rd never asserted; o_wr_ready=1 throughout.
